clock_div: RTL and testbench



---
 rtl/clock_div_if.sv | 13 +
 rtl/clock_div.sv | 47 ++++
 tb/tb_clock_div.sv | 103 ++++++++++
 3 files changed

// File: rtl/clock_div_if.sv
// clock_div_if: divided-clock outputs of clock_div bundled for the consumer.
// tick travels with clkout only when CLOCKDIV_TICK_EN is defined.
interface clock_div_if;
    logic clkout;
`ifdef CLOCKDIV_TICK_EN
    logic tick;
    modport master (output clkout, output tick);
    modport slave  (input  clkout, input  tick);
`else
    modport master (output clkout);
    modport slave  (input  clkout);
`endif
endinterface

// File: rtl/clock_div.sv
// clock_div: integer divider producing a registered square wave of period DIV clkin cycles.
// Optional single-cycle end-of-period tick when CLOCKDIV_TICK_EN is defined.
module clock_div #(
    parameter int DIV = 10000
) (
    input  logic               clkin,
    input  logic               rst,
    clock_div_if.master        o_bus
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LOW  = CW'(DIV - DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("clock_div: DIV must be >= 2");
    end

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_clkout;

    assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;

    // outputs are decoded from the next count so they align with r_cnt without a comb path
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_cnt    <= '0;
            r_clkout <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_clkout <= (w_cnt_nxt >= LOW);
        end
    end

    assign o_bus.clkout = r_clkout;

`ifdef CLOCKDIV_TICK_EN
    logic r_tick;

    always_ff @(posedge clkin) begin
        if (rst) r_tick <= 1'b0;
        else     r_tick <= (w_cnt_nxt == LAST);
    end

    assign o_bus.tick = r_tick;
`endif
endmodule

// File: tb/tb_clock_div.sv
// tb_clock_div: scoreboard bench driving DIV=4,5,2,10000 dividers from one clock/reset.
module tb_clock_div;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    clock_div_if if4();
    clock_div_if if5();
    clock_div_if if2();
    clock_div_if ifb();

    clock_div #(.DIV(4))     u4 (.clkin(clk), .rst(rst), .o_bus(if4));
    clock_div #(.DIV(5))     u5 (.clkin(clk), .rst(rst), .o_bus(if5));
    clock_div #(.DIV(2))     u2 (.clkin(clk), .rst(rst), .o_bus(if2));
    clock_div #(.DIV(10000)) ub (.clkin(clk), .rst(rst), .o_bus(ifb));

    typedef struct packed {
        logic c4;
        logic c5;
        logic c2;
        logic cb;
        logic t4;
        logic t2;
        int   p;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int p = 0;

    // hand-written per-phase waveforms, bit index = cycles since reset
    logic [3:0] pat4  = 4'b1100;
    logic [4:0] pat5  = 5'b11000;
    logic [1:0] pat2  = 2'b10;
    logic [3:0] tick4 = 4'b1000;

    task automatic check(input string name, input logic act, input logic exp, input int ph);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s phase=%0d got=%b want=%b", name, ph, act, exp);
        end
    endtask

    task automatic step(input logic r);
        exp_t e;
        rst = r;
        @(posedge clk);
        #1;
        p = r ? 0 : p + 1;
        e.p  = p;
        e.c4 = pat4[p % 4];
        e.c5 = pat5[p % 5];
        e.c2 = pat2[p % 2];
        e.cb = ((p % 10000) >= 5000);
        e.t4 = tick4[p % 4];
        e.t2 = pat2[p % 2];
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("clkout_div4", if4.clkout, e.c4, e.p);
                check("clkout_div5", if5.clkout, e.c5, e.p);
                check("clkout_div2", if2.clkout, e.c2, e.p);
                check("clkout_div10000", ifb.clkout, e.cb, e.p);
`ifdef CLOCKDIV_TICK_EN
                check("tick_div4", if4.tick, e.t4, e.p);
                check("tick_div2", if2.tick, e.t2, e.p);
`endif
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        repeat (2) step(1'b1);
        repeat (14) step(1'b0);
        // p%4 == 2 here: DIV=4 clkout is high when the single-cycle reset hits
        step(1'b1);
        repeat (25000) step(1'b0);
        repeat (3) step(1'b1);
        repeat (12) step(1'b0);
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
